// File: rtl/reset_sequencer.sv
// Staged reset release: after the last rst/restart edge all channels are held,
// then released one by one in ascending order, and done flags the end of the sequence.
module reset_sequencer #(
  parameter int CHANNELS     = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int ACTIVE_LEVEL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done,
  output logic [1:0]          state_o
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CNT >= 1) ? $clog2(MAX_CNT + 1) : 1;
  localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic ACT   = (ACTIVE_LEVEL != 0);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("reset_sequencer: CHANNELS must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("reset_sequencer: GAP_CYCLES must be >= 1");
  end
  if (ACTIVE_LEVEL != 0 && ACTIVE_LEVEL != 1) begin : g_bad_level
    $error("reset_sequencer: ACTIVE_LEVEL must be 0 or 1");
  end

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [CHANNELS-1:0] rst_out_q;
  logic                done_q;

  // cnt_q counts edges since the last trigger (HOLD) or since the previous release (RELEASE).
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= {CHANNELS{ACT}};
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            rst_out_q[0] <= ~ACT;
            cnt_q        <= '0;
            if (CHANNELS == 1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RELEASE;
              idx_q   <= IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            rst_out_q[idx_q] <= ~ACT;
            cnt_q            <= '0;
            if (idx_q == IW'(CHANNELS - 1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q   <= S_HOLD;
          cnt_q     <= '0;
          idx_q     <= '0;
          rst_out_q <= {CHANNELS{ACT}};
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out = rst_out_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations driven by shared rst/restart,
// a vector table, hand sequences for corner cases and random stimulus against a timing model.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0;

  logic [3:0] out_a, out_n;
  logic [0:0] out_1;
  logic       done_a, done_n, done_1;
  logic [1:0] st_a, st_n, st_1;

  int checks = 0;
  int failures = 0;
  int t = 0;

  typedef struct {
    logic       r;
    logic       rs;
    logic [3:0] out;
    logic       dn;
  } vec_t;

  vec_t vecs[$];
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(8), .GAP_CYCLES(2), .ACTIVE_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .restart(restart), .rst_out(out_a), .done(done_a), .state_o(st_a));
  reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(8), .GAP_CYCLES(2), .ACTIVE_LEVEL(0)) dut_n (
    .clk(clk), .rst(rst), .restart(restart), .rst_out(out_n), .done(done_n), .state_o(st_n));
  reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .ACTIVE_LEVEL(1)) dut_1 (
    .clk(clk), .rst(rst), .restart(restart), .rst_out(out_1), .done(done_1), .state_o(st_1));

  // Reference: channel k is released once t edges have passed since the last trigger
  // with t >= hold + k*gap; done once the last channel is released.
  function automatic logic [15:0] m_out(int tt, int c, int h, int g, logic al);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < c; k++) v[k] = (tt >= h + k * g) ? ~al : al;
    return v;
  endfunction

  function automatic logic m_done(int tt, int c, int h, int g);
    return (tt >= h + (c - 1) * g);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rs);
    @(negedge clk);
    rst = r;
    restart = rs;
    @(posedge clk);
    #1;
    if (r || rs) t = 0;
    else if (t < 100000) t++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out_a"}, {12'd0, out_a}, m_out(t, 4, 8, 2, 1'b1));
    chk({tag, "_done_a"}, {15'd0, done_a}, {15'd0, m_done(t, 4, 8, 2)});
    chk({tag, "_out_n"}, {12'd0, out_n}, m_out(t, 4, 8, 2, 1'b0));
    chk({tag, "_done_n"}, {15'd0, done_n}, {15'd0, m_done(t, 4, 8, 2)});
    chk({tag, "_out_1"}, {15'd0, out_1}, m_out(t, 1, 1, 1, 1'b1));
    chk({tag, "_done_1"}, {15'd0, done_1}, {15'd0, m_done(t, 1, 1, 1)});
  endtask

  task automatic add(input logic r, input logic rs, input logic [3:0] o, input logic d, input int n);
    vec_t v;
    v.r = r; v.rs = rs; v.out = o; v.dn = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] e;
    int         rnd;
    logic       rr, rrs;

    // Full sequence after 3 reset edges.
    add(1, 0, 4'b1111, 0, 3);
    add(0, 0, 4'b1111, 0, 7);
    add(0, 0, 4'b1110, 0, 2);
    add(0, 0, 4'b1100, 0, 2);
    add(0, 0, 4'b1000, 0, 2);
    add(0, 0, 4'b0000, 1, 3);
    // Restart pulse at T+11 with channels 0 and 1 already released.
    add(1, 0, 4'b1111, 0, 1);
    add(0, 0, 4'b1111, 0, 7);
    add(0, 0, 4'b1110, 0, 2);
    add(0, 0, 4'b1100, 0, 1);
    add(0, 1, 4'b1111, 0, 1);
    add(0, 0, 4'b1111, 0, 7);
    add(0, 0, 4'b1110, 0, 2);
    add(0, 0, 4'b1100, 0, 2);
    add(0, 0, 4'b1000, 0, 2);
    add(0, 0, 4'b0000, 1, 1);
    // rst and restart together, then restart held 5 more edges.
    add(1, 1, 4'b1111, 0, 1);
    add(0, 1, 4'b1111, 0, 5);
    add(0, 0, 4'b1111, 0, 7);
    add(0, 0, 4'b1110, 0, 2);
    add(0, 0, 4'b1100, 0, 2);
    add(0, 0, 4'b1000, 0, 2);
    add(0, 0, 4'b0000, 1, 1);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].dn, vecs[i].out});
      step(vecs[i].r, vecs[i].rs);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_out", i), {12'd0, out_a}, {12'd0, e[3:0]});
      chk($sformatf("vec%0d_done", i), {15'd0, done_a}, {15'd0, e[4]});
      chk($sformatf("vec%0d_out_inv", i), {12'd0, out_n}, {12'd0, ~e[3:0]});
      chk($sformatf("vec%0d_done_inv", i), {15'd0, done_n}, {15'd0, e[4]});
      chk($sformatf("vec%0d_ch1", i), {15'd0, out_1}, m_out(t, 1, 1, 1, 1'b1));
    end

    // DONE is absorbing: 100 idle edges with nothing moving.
    for (int i = 0; i < 100; i++) begin
      step(0, 0);
      chk("idle_out", {12'd0, out_a}, 16'h0000);
      chk("idle_done", {15'd0, done_a}, 16'h0001);
      chk("idle_out_inv", {12'd0, out_n}, 16'h000f);
    end

    // Single-channel, minimum-timing configuration.
    step(1, 0);
    chk("ch1_rst_out", {15'd0, out_1}, 16'h0001);
    chk("ch1_rst_done", {15'd0, done_1}, 16'h0000);
    step(0, 0);
    chk("ch1_rel_out", {15'd0, out_1}, 16'h0000);
    chk("ch1_rel_done", {15'd0, done_1}, 16'h0001);
    step(0, 1);
    chk("ch1_restart_out", {15'd0, out_1}, 16'h0001);
    chk("ch1_restart_done", {15'd0, done_1}, 16'h0000);
    step(0, 0);
    chk("ch1_rerel_out", {15'd0, out_1}, 16'h0000);
    chk("ch1_rerel_done", {15'd0, done_1}, 16'h0001);

    // Random triggers, including aborts mid-HOLD and mid-RELEASE.
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom_range(0, 99);
      rr  = (rnd < 3);
      rrs = (rnd >= 3 && rnd < 8) || (rnd == 50 && rr);
      step(rr, rrs);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
